ieeedrv_sd_arb: RTL and testbench

Arbitrates the single MiSTer SD block-device host port among NREQ sub-drive requesters: NDR drives × NSD sub-units.
Each requester presents an lba, block count and a rd/wr request. The arbiter grants one requester round-robin, forwards its request to the host port and routes ack and buffer traffic back to it. It holds the grant until the host transfer completes.
It sits between the ieeedrv_drv instances and the top-level sd_* ports.
sd_buff_addr and sd_buff_dout are broadcast to all requesters outside this block.

---
 rtl/ieeedrv_pkg.sv | 14 +
 rtl/ieeedrv_rr_pick.sv | 27 ++
 rtl/ieeedrv_sd_arb.sv | 170 +++++++++++++++++
 tb/tb_ieeedrv_sd_arb.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ieeedrv_pkg.sv
// Shared ieeedrv definitions: SD arbiter state type and requester/grant sizing.
package ieeedrv_pkg;

  localparam int IEEEDRV_MAX_REQ = 8;
  localparam int IEEEDRV_GRANT_W = 3;

  typedef enum logic [1:0] {
    SDARB_IDLE = 2'd0,
    SDARB_REQ  = 2'd1,
    SDARB_XFER = 2'd2,
    SDARB_DONE = 2'd3
  } st_sdarb_state;

endpackage

// File: rtl/ieeedrv_rr_pick.sv
// Combinational round-robin picker: first pending index strictly after last_i, wrapping.
module ieeedrv_rr_pick
  import ieeedrv_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]            pending_i,
  input  logic [IEEEDRV_GRANT_W-1:0] last_i,
  output logic                       valid_o,
  output logic [IEEEDRV_GRANT_W-1:0] idx_o
);

  // Walk distances from far to near so the nearest pending index is written last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int j = 0; j < NREQ; j++) begin
        if ((j == (int'(last_i) + k) % NREQ) && pending_i[j]) begin
          valid_o = 1'b1;
          idx_o   = IEEEDRV_GRANT_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/ieeedrv_sd_arb.sv
// Round-robin arbiter sharing the single SD block-device host port among NREQ sub-drive requesters.
module ieeedrv_sd_arb
  import ieeedrv_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int TMO_W = 24
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic [31:0]                req_lba      [NREQ],
  input  logic [5:0]                 req_blk_cnt  [NREQ],
  input  logic [NREQ-1:0]            req_rd,
  input  logic [NREQ-1:0]            req_wr,
  output logic [NREQ-1:0]            req_ack,
  input  logic [7:0]                 req_buff_din [NREQ],
  output logic [NREQ-1:0]            req_buff_wr,
  output logic [31:0]                sd_lba,
  output logic [5:0]                 sd_blk_cnt,
  output logic                       sd_rd,
  output logic                       sd_wr,
  input  logic                       sd_ack,
  input  logic                       sd_buff_wr,
  output logic [7:0]                 sd_buff_din,
  output logic                       busy,
  output logic [IEEEDRV_GRANT_W-1:0] grant,
  output logic                       timeout
);

  localparam int GW = IEEEDRV_GRANT_W;
  localparam logic [GW-1:0] LAST_RST = GW'(NREQ - 1);

  st_sdarb_state     state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q, last_d;
  logic [31:0]       lba_q, lba_d;
  logic [5:0]        blk_q, blk_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              tmo_q, tmo_d;
  logic [TMO_W-1:0]  wdog_q, wdog_d;

  logic [NREQ-1:0]   pending;
  logic              pick_valid;
  logic [GW-1:0]     pick_idx;
  logic [31:0]       lba_sel;
  logic [5:0]        blk_sel;
  logic              rd_sel;
  logic              active;

  assign pending = req_rd | req_wr;

  ieeedrv_rr_pick #(.NREQ(NREQ)) u_pick (
    .pending_i (pending),
    .last_i    (last_q),
    .valid_o   (pick_valid),
    .idx_o     (pick_idx)
  );

  always_comb begin
    lba_sel = '0;
    blk_sel = '0;
    rd_sel  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == GW'(i)) begin
        lba_sel = req_lba[i];
        blk_sel = req_blk_cnt[i];
        rd_sel  = req_rd[i];
      end
    end
  end

  // Requests are sampled only at the IDLE pick; a withdrawn request still runs to completion.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    lba_d   = lba_q;
    blk_d   = blk_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdog_d  = wdog_q;
    tmo_d   = 1'b0;
    case (state_q)
      SDARB_IDLE: begin
        if (pick_valid) begin
          state_d = SDARB_REQ;
          grant_d = pick_idx;
          lba_d   = lba_sel;
          blk_d   = blk_sel;
          rd_d    = rd_sel;
          wr_d    = !rd_sel;
          wdog_d  = '0;
        end
      end
      SDARB_REQ: begin
        if (sd_ack) begin
          state_d = SDARB_XFER;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          wdog_d  = '0;
        end else if (&wdog_q) begin
          state_d = SDARB_DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          wdog_d  = '0;
          tmo_d   = 1'b1;
        end else begin
          wdog_d  = wdog_q + 1'b1;
        end
      end
      SDARB_XFER: begin
        if (!sd_ack) state_d = SDARB_DONE;
      end
      SDARB_DONE: begin
        last_d  = grant_q;
        state_d = SDARB_IDLE;
      end
      default: state_d = SDARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= SDARB_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      lba_q   <= '0;
      blk_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      tmo_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      lba_q   <= lba_d;
      blk_q   <= blk_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      tmo_q   <= tmo_d;
      wdog_q  <= wdog_d;
    end
  end

  // Host-side ack/strobe routing back to the granted requester is combinational.
  assign active = (state_q == SDARB_REQ) || (state_q == SDARB_XFER);

  always_comb begin
    req_ack     = '0;
    req_buff_wr = '0;
    sd_buff_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == GW'(i)) begin
        req_ack[i]     = sd_ack & active;
        req_buff_wr[i] = sd_buff_wr & (state_q == SDARB_XFER);
        if (active) sd_buff_din = req_buff_din[i];
      end
    end
  end

  assign sd_lba     = lba_q;
  assign sd_blk_cnt = blk_q;
  assign sd_rd      = rd_q;
  assign sd_wr      = wr_q;
  assign busy       = (state_q != SDARB_IDLE);
  assign grant      = grant_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_ieeedrv_sd_arb.sv
// Self-checking bench for ieeedrv_sd_arb with four requesters and a short watchdog.
module tb_ieeedrv_sd_arb;

  localparam int NREQ  = 4;
  localparam int TMO_W = 4;
  localparam int EW    = 43;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [31:0] req_lba      [NREQ];
  logic [5:0]  req_blk_cnt  [NREQ];
  logic [7:0]  req_buff_din [NREQ];
  logic [3:0]  req_rd, req_wr, req_ack, req_buff_wr;
  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic        sd_rd, sd_wr, sd_ack, sd_buff_wr, busy, timeout;
  logic [7:0]  sd_buff_din;
  logic [2:0]  grant;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp, mon_got;
  logic          prev_req = 1'b0;

  always #5 clk_sys = ~clk_sys;

  ieeedrv_sd_arb #(.NREQ(NREQ), .TMO_W(TMO_W)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .req_lba      (req_lba),
    .req_blk_cnt  (req_blk_cnt),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_ack      (req_ack),
    .req_buff_din (req_buff_din),
    .req_buff_wr  (req_buff_wr),
    .sd_lba       (sd_lba),
    .sd_blk_cnt   (sd_blk_cnt),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .busy         (busy),
    .grant        (grant),
    .timeout      (timeout)
  );

  function automatic logic [EW-1:0] mk(input int g, input bit rd, input bit wr,
                                       input logic [5:0] blk, input logic [31:0] lba);
    return {3'(g), rd, wr, blk, lba};
  endfunction

  // Scoreboard: every new host request is compared against the oldest expectation.
  always @(negedge clk_sys) begin
    if ((sd_rd | sd_wr) && !prev_req) begin
      n_tests++;
      mon_got = {grant, sd_rd, sd_wr, sd_blk_cnt, sd_lba};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_req: unexpected host request got=%h required=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_req: got=%h required=%h", mon_got, mon_exp);
        end
      end
    end
    prev_req = sd_rd | sd_wr;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic wait_req(input string tag);
    int n = 0;
    while (!(sd_rd | sd_wr) && n < 40) begin
      @(negedge clk_sys);
      n++;
    end
    n_tests++;
    if (!(sd_rd | sd_wr)) begin
      n_fail++;
      $display("FAIL %s_wait: got no host request after %0d cycles, required one", tag, n);
    end
  endtask

  // Host model: ack, nbytes buffer strobes, release ack, then watch DONE -> IDLE.
  task automatic serve(input int g, input int nbytes, input bit drop);
    logic [1:0] gi;
    logic [3:0] oh;
    gi = 2'(g);
    oh = 4'b0001 << g;
    sd_ack = 1'b1;
    #1;
    n_tests++;
    if (req_ack !== oh) begin
      n_fail++; $display("FAIL serve_ack: got=%b required=%b", req_ack, oh);
    end
    if (drop) begin req_rd[gi] = 1'b0; req_wr[gi] = 1'b0; end
    @(negedge clk_sys);
    n_tests++;
    if ({sd_rd, sd_wr, busy} !== 3'b001) begin
      n_fail++; $display("FAIL serve_xfer: rd/wr/busy got=%b required=001", {sd_rd, sd_wr, busy});
    end
    for (int b = 0; b < nbytes; b++) begin
      foreach (req_buff_din[k]) req_buff_din[k] = 8'($urandom_range(0, 255));
      sd_buff_wr = 1'b1;
      #1;
      n_tests++;
      if (req_buff_wr !== oh) begin
        n_fail++; $display("FAIL serve_buff_wr: got=%b required=%b", req_buff_wr, oh);
      end
      n_tests++;
      if (sd_buff_din !== req_buff_din[gi]) begin
        n_fail++; $display("FAIL serve_buff_din: got=%h required=%h", sd_buff_din, req_buff_din[gi]);
      end
      @(negedge clk_sys);
      sd_buff_wr = 1'b0;
      @(negedge clk_sys);
    end
    sd_ack = 1'b0;
    @(negedge clk_sys);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL serve_done_busy: got=%b required=1", busy);
    end
    @(negedge clk_sys);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL serve_idle_busy: got=%b required=0", busy);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_rd = '0; req_wr = '0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    foreach (req_lba[k]) begin
      req_lba[k] = '0; req_blk_cnt[k] = '0; req_buff_din[k] = '0;
    end
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if ({busy, sd_rd, sd_wr, timeout, req_ack, req_buff_wr, grant} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got=%b required=0",
               {busy, sd_rd, sd_wr, timeout, req_ack, req_buff_wr, grant});
    end
    n_tests++;
    if ({sd_lba, sd_blk_cnt, sd_buff_din} !== 46'd0) begin
      n_fail++; $display("FAIL reset_data: lba=%h blk=%h din=%h required 0", sd_lba, sd_blk_cnt, sd_buff_din);
    end
    reset = 1'b0;
    @(negedge clk_sys);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy got=%b required=0", busy);
    end
  endtask

  task automatic test_single_read();
    req_lba[0] = 32'h123; req_blk_cnt[0] = 6'd3; req_rd[0] = 1'b1;
    exp_q.push_back(mk(0, 1, 0, 6'd3, 32'h123));
    @(negedge clk_sys);
    n_tests++;
    if ({sd_rd, sd_wr, sd_lba, sd_blk_cnt} !== {2'b10, 32'h123, 6'd3}) begin
      n_fail++; $display("FAIL single_issue: rd=%b wr=%b lba=%h blk=%0d required rd=1 wr=0 lba=123 blk=3",
                         sd_rd, sd_wr, sd_lba, sd_blk_cnt);
    end
    serve(0, 4, 1'b1);
  endtask

  task automatic test_contention();
    apply_reset();
    reset = 1'b0;
    @(negedge clk_sys);
    req_lba[1] = 32'h1111_0001; req_blk_cnt[1] = 6'd5; req_rd[1] = 1'b1;
    req_lba[3] = 32'h3333_0003; req_blk_cnt[3] = 6'd7; req_wr[3] = 1'b1;
    exp_q.push_back(mk(1, 1, 0, 6'd5, 32'h1111_0001));
    exp_q.push_back(mk(3, 0, 1, 6'd7, 32'h3333_0003));
    wait_req("cont1");
    n_tests++;
    if (grant !== 3'd1) begin
      n_fail++; $display("FAIL cont_first_grant: got=%0d required=1", grant);
    end
    serve(1, 2, 1'b1);
    wait_req("cont3");
    n_tests++;
    if ({grant, sd_wr} !== {3'd3, 1'b1}) begin
      n_fail++; $display("FAIL cont_second_grant: grant=%0d wr=%b required grant=3 wr=1", grant, sd_wr);
    end
    serve(3, 3, 1'b1);
  endtask

  task automatic test_fairness();
    for (int k = 0; k < NREQ; k++) begin
      req_lba[k] = 32'hA000_0000 + 32'(k); req_blk_cnt[k] = 6'(k + 1);
    end
    req_rd = 4'hF;
    for (int t = 0; t < 8; t++)
      exp_q.push_back(mk(t % 4, 1, 0, 6'((t % 4) + 1), 32'hA000_0000 + 32'(t % 4)));
    for (int t = 0; t < 8; t++) begin
      wait_req("fair");
      n_tests++;
      if (grant !== 3'(t % 4)) begin
        n_fail++; $display("FAIL fair_grant[%0d]: got=%0d required=%0d", t, grant, t % 4);
      end
      serve(t % 4, 1, 1'b0);
    end
    req_rd = '0;
  endtask

  task automatic test_rd_wr_priority();
    req_lba[0] = 32'h0BAD_F00D; req_blk_cnt[0] = 6'd63;
    req_rd[0] = 1'b1; req_wr[0] = 1'b1;
    exp_q.push_back(mk(0, 1, 0, 6'd63, 32'h0BAD_F00D));
    wait_req("rdwr");
    n_tests++;
    if ({sd_rd, sd_wr} !== 2'b10) begin
      n_fail++; $display("FAIL rdwr_dir: rd/wr got=%b required=10", {sd_rd, sd_wr});
    end
    serve(0, 2, 1'b1);
  endtask

  task automatic test_stray_ack();
    sd_ack = 1'b1;
    #1;
    n_tests++;
    if (req_ack !== 4'b0000) begin
      n_fail++; $display("FAIL stray_ack: req_ack got=%b required=0000", req_ack);
    end
    @(negedge clk_sys);
    sd_buff_wr = 1'b1;
    #1;
    n_tests++;
    if ({busy, req_ack, req_buff_wr, sd_buff_din} !== 17'd0) begin
      n_fail++; $display("FAIL stray_idle: busy=%b ack=%b bwr=%b din=%h required all 0",
                         busy, req_ack, req_buff_wr, sd_buff_din);
    end
    @(negedge clk_sys);
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    @(negedge clk_sys);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL stray_after: busy got=%b required=0", busy);
    end
  endtask

  task automatic test_reset_mid_xfer();
    req_lba[2] = 32'h2222_2222; req_blk_cnt[2] = 6'd2; req_rd[2] = 1'b1;
    exp_q.push_back(mk(2, 1, 0, 6'd2, 32'h2222_2222));
    wait_req("mid");
    sd_ack = 1'b1;
    @(negedge clk_sys);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({busy, sd_rd, sd_wr, timeout, req_ack, grant, sd_lba, sd_blk_cnt, sd_buff_din} !== 57'd0) begin
      n_fail++; $display("FAIL mid_reset: busy=%b ack=%b grant=%0d lba=%h blk=%0d din=%h required all 0",
                         busy, req_ack, grant, sd_lba, sd_blk_cnt, sd_buff_din);
    end
    sd_ack = 1'b0;
    req_lba[0] = 32'h0000_0C0C; req_blk_cnt[0] = 6'd1; req_rd[0] = 1'b1;
    exp_q.push_back(mk(0, 1, 0, 6'd1, 32'h0000_0C0C));
    exp_q.push_back(mk(2, 1, 0, 6'd2, 32'h2222_2222));
    @(negedge clk_sys);
    reset = 1'b0;
    wait_req("mid0");
    n_tests++;
    if (grant !== 3'd0) begin
      n_fail++; $display("FAIL mid_order0: grant got=%0d required=0", grant);
    end
    serve(0, 1, 1'b1);
    wait_req("mid2");
    n_tests++;
    if (grant !== 3'd2) begin
      n_fail++; $display("FAIL mid_order2: grant got=%0d required=2", grant);
    end
    serve(2, 1, 1'b1);
  endtask

  task automatic test_watchdog();
    int  cnt = 0;
    bit  bad = 1'b0;
    req_lba[0] = 32'h77; req_blk_cnt[0] = 6'd1; req_rd[0] = 1'b1;
    exp_q.push_back(mk(0, 1, 0, 6'd1, 32'h77));
    exp_q.push_back(mk(0, 1, 0, 6'd1, 32'h77));
    wait_req("wdog");
    while (sd_rd && cnt < 40) begin
      if (req_ack !== 4'b0000 || timeout !== 1'b0) bad = 1'b1;
      cnt++;
      @(negedge clk_sys);
    end
    n_tests++;
    if (cnt != 16 || bad) begin
      n_fail++; $display("FAIL wdog_window: sd_rd cycles got=%0d required=16 (early ack/timeout=%0b)", cnt, bad);
    end
    n_tests++;
    if ({timeout, busy, req_ack} !== 6'b110000) begin
      n_fail++; $display("FAIL wdog_pulse: timeout=%b busy=%b ack=%b required 1 1 0000", timeout, busy, req_ack);
    end
    @(negedge clk_sys);
    n_tests++;
    if ({timeout, busy, sd_rd} !== 3'b000) begin
      n_fail++; $display("FAIL wdog_idle: timeout/busy/rd got=%b required=000", {timeout, busy, sd_rd});
    end
    @(negedge clk_sys);
    n_tests++;
    if ({sd_rd, grant} !== {1'b1, 3'd0}) begin
      n_fail++; $display("FAIL wdog_reissue: rd=%b grant=%0d required rd=1 grant=0", sd_rd, grant);
    end
    serve(0, 1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_fairness();
    test_rd_wr_priority();
    test_stray_ack();
    test_reset_mid_xfer();
    test_watchdog();
    repeat (3) @(negedge clk_sys);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: %0d expected requests never seen, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
